uart_tx_fsm: RTL and testbench
==============================

Name: uart_tx_fsm

Overview:
UART transmitter; the transmit end of the same serial link whose receiver is already in the codebase. It accepts a parallel byte through a Start/Ready handshake and serializes it onto Tx: start bit, data LSB first, optional parity, then stop bit(s). Tx idles high. An internal baud counter times each bit period from Clk.

Parameters:
CLKS_PER_BIT, 434, Clk cycles per serial bit period (≥2); 434 gives 115200 baud at 50 MHz.
DATA_BITS, 8, number of data bits per frame (5..8).
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, 0 selects even parity, 1 selects odd parity (used only if PARITY_EN=1).
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
Clk  input  1  system clock; all logic on rising edge.
Rst  input  1  synchronous, active-high reset.
Data  input  DATA_BITS  byte to send; sampled only on an accepted Start.
Start  input  1  request to send; accepted when Start=1 and Ready=1 at a rising edge.
Ready  output  1  1 only in Idle; transmitter can accept a frame.
Tx  output  1  serial line, registered, idle high.
Busy  output  1  1 in every state except Idle.
Done  output  1  one-cycle pulse on the final cycle of the last stop bit.

Behaviour:
- Reset (Rst=1 at edge): state=Idle, Tx=1, Ready=1, Busy=0, Done=0, baud counter=0, bit index=0, shift register=0. Reset overrides everything, including mid-frame: the frame is aborted and Tx=1 from the next edge on.
- States: Idle, StartBit, DataBits, ParityBit, StopBits.
- Idle: Tx=1. On Start&Ready, latch Data into the shift register and compute the parity bit from the latched value. Go to StartBit; Tx=0 after that same edge (1-cycle latency from acceptance to start-bit edge). Start=0 keeps the block in Idle.
- Baud counter: resets to 0 on every state or bit entry and counts 0..CLKS_PER_BIT-1. Each bit is held on Tx for exactly CLKS_PER_BIT cycles.
- StartBit: Tx=0 for CLKS_PER_BIT cycles, then go to DataBits with bit index 0.
- DataBits: Tx=shift[0]. At the end of each bit period, shift right and increment the index. After bit DATA_BITS-1, go to ParityBit if PARITY_EN=1, otherwise to StopBits.
- ParityBit: Tx = XOR of the latched data bits, inverted when PARITY_ODD=1. Held for CLKS_PER_BIT cycles, then go to StopBits.
- StopBits: Tx=1 for STOP_BITS*CLKS_PER_BIT cycles. Done=1 exactly on the final cycle of this period, then go to Idle.
- Frame length from the first Tx=0 cycle to the Done cycle inclusive is CLKS_PER_BIT*(1+DATA_BITS+PARITY_EN+STOP_BITS) cycles.
- Back-to-back frames: Ready rises on the cycle after Done. If Start is held high, the next frame starts with exactly one extra Tx=1 Idle cycle between frames.
- Start while Busy: ignored, not queued. Changes on Data while Busy do not affect the frame in flight.
- Tx is driven only from a register, never combinationally from the state, so it has no glitches.
- Unused state encodings recover to Idle on the next edge with Tx=1.

Test Plan:
- Reset then idle: Rst=1 for 3 cycles, Start=0 -> Tx=1, Ready=1, Busy=0, Done=0 throughout, including the cycles under reset.
- Basic 8N1 with CLKS_PER_BIT=4: send Data=8'hA5 -> Tx sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,1. Done pulses once, 40 cycles after the first Tx=0 cycle. Ready returns the next cycle.
- Parity with PARITY_EN=1, CLKS_PER_BIT=4: Data=8'h07 with PARITY_ODD=0 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0. Frame is 44 cycles.
- Two stop bits with STOP_BITS=2: Data=8'h00 -> Tx high for 8 cycles after the data bits, Done on the 8th.
- Handshake abuse: pulse Start with Data=8'h3C mid-frame of an 8'hA5 send -> 8'hA5 is transmitted intact and 8'h3C is never sent. Hold Start=1 with Data=8'h55 -> two frames separated by exactly one idle cycle.
- Reset mid-frame: assert Rst during data bit 3 -> Tx=1 and Ready=1 on the next edge, no Done pulse. A new Start afterwards produces a complete, correct frame.

Source files
------------

// File: rtl/uart_tx_fsm_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fsm_if
// Parallel-side handshake bundle of the UART transmitter plus its serial and
// status outputs.
//   Data  : byte to send (sampled only on an accepted Start)
//   Start : request to send a frame
//   Ready : transmitter is idle and will accept Start
//   Tx    : serial line, idles high
//   Busy  : a frame is in flight
//   Done  : one-cycle pulse on the last cycle of the last stop bit
// The master modport is the client that hands bytes over; the slave modport
// is the transmitter itself.
// ---------------------------------------------------------------------------
interface uart_tx_fsm_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] Data;
    logic                 Start;
    logic                 Ready;
    logic                 Tx;
    logic                 Busy;
    logic                 Done;

    modport master (
        output Data,
        output Start,
        input  Ready,
        input  Tx,
        input  Busy,
        input  Done
    );

    modport slave (
        input  Data,
        input  Start,
        output Ready,
        output Tx,
        output Busy,
        output Done
    );
endinterface

// File: rtl/uart_tx_fsm.sv
// ---------------------------------------------------------------------------
// uart_tx_fsm
// UART transmitter. Accepts a parallel word through a Start/Ready handshake
// and serializes it: start bit, data LSB first, optional parity bit, then one
// or two stop bits. Each bit lasts CLKS_PER_BIT clock cycles.
// Ports:
//   Clk : system clock, rising edge
//   Rst : synchronous active-high reset, aborts any frame in flight
//   bus : slave side of uart_tx_fsm_if (Data/Start in, Ready/Tx/Busy/Done out)
// All outputs come straight from flops; their next values are decoded from
// the next-state signals so each flop holds what the current state implies.
// ---------------------------------------------------------------------------
module uart_tx_fsm #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic           Clk,
    input  logic           Rst,
    uart_tx_fsm_if.slave   bus
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [2:0]    LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0]    LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic          ODD_SEL   = (PARITY_ODD != 0) ? 1'b1 : 1'b0;
    localparam logic          PAR_ON    = (PARITY_EN != 0) ? 1'b1 : 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Parity of a data word: even parity is the plain XOR, odd inverts it.
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (^d) ^ ODD_SEL;
    endfunction

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;     // data bit index, reused as stop bit index
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 ready_q, ready_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 bit_end_s;

    assign bit_end_s = (cnt_q == CNT_MAX);

    // Next-state, counter and datapath decode; outputs derived from next state.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_ONE;
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = CNT_ZERO;
                bit_d = 3'd0;
                if (bus.Start) begin
                    shift_d  = bus.Data;
                    parity_d = parity_of(bus.Data);
                    state_d  = ST_START;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    cnt_d   = CNT_ZERO;
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    cnt_d   = CNT_ZERO;
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    if (bit_q == LAST_DATA) begin
                        bit_d   = 3'd0;
                        state_d = PAR_ON ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (bit_end_s) begin
                    cnt_d   = CNT_ZERO;
                    bit_d   = 3'd0;
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    cnt_d = CNT_ZERO;
                    if (bit_q == LAST_STOP) begin
                        bit_d   = 3'd0;
                        state_d = ST_IDLE;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                // Illegal encoding: fall back to a clean idle line.
                state_d  = ST_IDLE;
                cnt_d    = CNT_ZERO;
                bit_d    = 3'd0;
                shift_d  = '0;
                parity_d = 1'b0;
            end
        endcase

        // Line level for the cycle that starts at the coming edge.
        case (state_d)
            ST_IDLE:   tx_d = 1'b1;
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = parity_d;
            ST_STOP:   tx_d = 1'b1;
            default:   tx_d = 1'b1;
        endcase

        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
        // Done marks the last cycle of the last stop bit.
        done_d  = (state_d == ST_STOP) && (cnt_d == CNT_MAX) && (bit_d == LAST_STOP);
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= CNT_ZERO;
            bit_q    <= 3'd0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.Tx    = tx_q;
    assign bus.Ready = ready_q;
    assign bus.Busy  = busy_q;
    assign bus.Done  = done_q;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Bench for uart_tx_fsm. Four instances cover 8N1, 8E1, 8O1 and 8N2 with
// four clocks per bit. Stimulus pushes hand-written expected frames (line
// bit sequence, first bit in position 0) into a queue; one monitor per
// instance decodes frames off Tx and compares them against the queue.
module tb_uart_tx_fsm;

    localparam int CPB = 4;

    logic Clk;
    logic Rst;

    uart_tx_fsm_if #(.DATA_BITS(8)) ifa ();
    uart_tx_fsm_if #(.DATA_BITS(8)) ifb ();
    uart_tx_fsm_if #(.DATA_BITS(8)) ifc ();
    uart_tx_fsm_if #(.DATA_BITS(8)) ifd ();

    uart_tx_fsm #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
        u_n1 (.Clk(Clk), .Rst(Rst), .bus(ifa.slave));
    uart_tx_fsm #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
        u_e1 (.Clk(Clk), .Rst(Rst), .bus(ifb.slave));
    uart_tx_fsm #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1))
        u_o1 (.Clk(Clk), .Rst(Rst), .bus(ifc.slave));
    uart_tx_fsm #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2))
        u_n2 (.Clk(Clk), .Rst(Rst), .bus(ifd.slave));

    logic [3:0] tx_w, done_w, rdy_w;
    assign tx_w   = {ifd.Tx,    ifc.Tx,    ifb.Tx,    ifa.Tx};
    assign done_w = {ifd.Done,  ifc.Done,  ifb.Done,  ifa.Done};
    assign rdy_w  = {ifd.Ready, ifc.Ready, ifb.Ready, ifa.Ready};

    typedef struct {
        int          dut;
        logic [11:0] seq;
        int          nbits;
        bit          abort;
        int          gap;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Frames as seen on the line, bit 0 sent first.
    localparam logic [11:0] SEQ_A5   = 12'b0011_0100_1010; // 0,1,0,1,0,0,1,0,1,1
    localparam logic [11:0] SEQ_55   = 12'b0010_1010_1010; // 0,1,0,1,0,1,0,1,0,1
    localparam logic [11:0] SEQ_07E  = 12'b0110_0000_1110; // start, 11100000, par 1, stop
    localparam logic [11:0] SEQ_07O  = 12'b0100_0000_1110; // start, 11100000, par 0, stop
    localparam logic [11:0] SEQ_00S2 = 12'b0110_0000_0000; // start, 00000000, stop, stop

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic void check(input string name, input int got, input int want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endfunction

    function automatic void expect_frame(input int dut, input logic [11:0] seq,
                                         input int nbits, input bit abort, input int gap);
        exp_t e;
        e.dut = dut; e.seq = seq; e.nbits = nbits; e.abort = abort; e.gap = gap;
        exp_q.push_back(e);
    endfunction

    task automatic drive(input int idx, input logic st, input logic [7:0] d);
        case (idx)
            0: begin ifa.Start = st; ifa.Data = d; end
            1: begin ifb.Start = st; ifb.Data = d; end
            2: begin ifc.Start = st; ifc.Data = d; end
            3: begin ifd.Start = st; ifd.Data = d; end
            default: ;
        endcase
    endtask

    task automatic send(input int idx, input logic [7:0] d);
        @(posedge Clk); #1;
        drive(idx, 1'b1, d);
        @(posedge Clk); #1;
        drive(idx, 1'b0, d);
    endtask

    task automatic monitor(input int idx);
        exp_t        e;
        logic [11:0] got;
        int          cyc, done_at, idle_n;
        bit          in_frame, glitch, chk_rdy, by_rst;
        in_frame = 1'b0; chk_rdy = 1'b0; idle_n = 0;
        cyc = 0; done_at = 0; glitch = 1'b0; by_rst = 1'b0; got = '0;
        forever begin
            @(negedge Clk);
            if (!in_frame) begin
                if (!Rst && tx_w[idx] === 1'b0) begin
                    in_frame = 1'b1; cyc = 0; got = '0; glitch = 1'b0;
                    done_at = 0; by_rst = 1'b0;
                    if (exp_q.size() == 0) begin
                        check($sformatf("unexpected_frame_dut%0d", idx), 1, 0);
                        e.dut = idx; e.seq = '0; e.nbits = 12; e.abort = 1'b0; e.gap = -1;
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_on_dut", idx, e.dut);
                        if (e.gap >= 0) check("idle_gap", idle_n, e.gap);
                    end
                end else begin
                    idle_n++;
                    if (chk_rdy) begin
                        check($sformatf("ready_after_done_dut%0d", idx), int'(rdy_w[idx]), 1);
                        check($sformatf("done_one_cycle_dut%0d", idx), int'(done_w[idx]), 0);
                        chk_rdy = 1'b0;
                    end
                end
            end
            if (in_frame) begin
                if (Rst) begin
                    by_rst = 1'b1;
                end else begin
                    if (cyc % CPB == 0) got[cyc / CPB] = tx_w[idx];
                    else if (tx_w[idx] !== got[cyc / CPB]) glitch = 1'b1;
                    cyc++;
                    if (done_w[idx] === 1'b1) done_at = cyc;
                end
                if (by_rst || done_at != 0 || cyc >= 48) begin
                    in_frame = 1'b0;
                    idle_n   = 0;
                    check($sformatf("aborted_dut%0d", idx), int'(by_rst), int'(e.abort));
                    if (!by_rst) begin
                        check($sformatf("frame_bits_dut%0d", idx), int'(got), int'(e.seq));
                        check($sformatf("bit_steady_dut%0d", idx), int'(glitch), 0);
                        check($sformatf("done_cycle_dut%0d", idx), done_at, e.nbits * CPB);
                        chk_rdy = (done_at != 0);
                    end
                end
            end
        end
    endtask

    initial begin
        fork
            monitor(0);
            monitor(1);
            monitor(2);
            monitor(3);
        join_none
    end

    initial begin
        Rst = 1'b1;
        for (int i = 0; i < 4; i++) drive(i, 1'b0, 8'h00);

        // Reset held for three edges with Start low.
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            check("rst_tx", int'(ifa.Tx), 1);
            check("rst_ready", int'(ifa.Ready), 1);
            check("rst_busy", int'(ifa.Busy), 0);
            check("rst_done", int'(ifa.Done), 0);
        end
        @(posedge Clk); #1;
        Rst = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("idle_tx", int'(ifa.Tx), 1);
        check("idle_ready", int'(ifa.Ready), 1);

        // Plain 8N1 frame.
        expect_frame(0, SEQ_A5, 10, 1'b0, -1);
        send(0, 8'hA5);
        repeat (50) @(posedge Clk);

        // Start pulsed mid-frame with different data is ignored.
        expect_frame(0, SEQ_A5, 10, 1'b0, -1);
        send(0, 8'hA5);
        repeat (10) @(posedge Clk);
        #1;
        check("busy_midframe", int'(ifa.Busy), 1);
        check("ready_midframe", int'(ifa.Ready), 0);
        drive(0, 1'b1, 8'h3C);
        @(posedge Clk); #1;
        drive(0, 1'b0, 8'h3C);
        repeat (50) @(posedge Clk);

        // Even and odd parity.
        expect_frame(1, SEQ_07E, 11, 1'b0, -1);
        send(1, 8'h07);
        repeat (55) @(posedge Clk);
        expect_frame(2, SEQ_07O, 11, 1'b0, -1);
        send(2, 8'h07);
        repeat (55) @(posedge Clk);

        // Two stop bits.
        expect_frame(3, SEQ_00S2, 11, 1'b0, -1);
        send(3, 8'h00);
        repeat (55) @(posedge Clk);

        // Start held high: two frames with one idle cycle between.
        expect_frame(0, SEQ_55, 10, 1'b0, -1);
        expect_frame(0, SEQ_55, 10, 1'b0, 1);
        @(posedge Clk); #1;
        drive(0, 1'b1, 8'h55);
        repeat (60) @(posedge Clk);
        #1;
        drive(0, 1'b0, 8'h55);
        repeat (45) @(posedge Clk);

        // Reset during data bit 3 aborts the frame.
        expect_frame(0, SEQ_A5, 10, 1'b1, -1);
        send(0, 8'hA5);
        repeat (18) @(posedge Clk);
        #1;
        Rst = 1'b1;
        @(posedge Clk); #1;
        check("abort_tx", int'(ifa.Tx), 1);
        check("abort_ready", int'(ifa.Ready), 1);
        check("abort_busy", int'(ifa.Busy), 0);
        check("abort_done", int'(ifa.Done), 0);
        Rst = 1'b0;
        repeat (2) @(posedge Clk);

        // A fresh frame after the abort is complete and correct.
        expect_frame(0, SEQ_A5, 10, 1'b0, -1);
        send(0, 8'hA5);
        repeat (50) @(posedge Clk);

        check("frames_outstanding", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
